// File: rtl/uart_bus_master.sv
// UART command-frame bus master: decodes write/read frames from the byte stream, issues one
// bus strobe per frame and returns an acknowledge or the read data over the transmit channel.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        rd_o,
  output logic        wr_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic          is_wr_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   resp_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          rd_q;
  logic          wr_q;
  logic          overrun_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      is_wr_q    <= 1'b0;
      timer_q    <= '0;
      resp_q     <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid_i) begin
            cnt_q <= 2'd0;
            if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
              is_wr_q <= (rx_data_i == CMD_WR);
              timer_q <= '0;
              state_q <= StAddr;
            end else begin
              tx_data_q  <= 8'h3F;
              tx_valid_q <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StAddr, StData: begin
          // An arriving byte takes priority over an expiring timer.
          if (rx_valid_i) begin
            timer_q <= '0;
            cnt_q   <= cnt_q + 2'd1;
            if (state_q == StAddr) addr_q <= {addr_q[23:0], rx_data_i};
            else                   wdata_q <= {wdata_q[23:0], rx_data_i};
            if (cnt_q == 2'd3) begin
              if (state_q == StAddr && is_wr_q) begin
                state_q <= StData;
              end else begin
                state_q <= StBus;
                wr_q    <= is_wr_q;
                rd_q    <= !is_wr_q;
              end
            end
          end else if (timer_q == TimerMax) begin
            timer_q <= '0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StBus: begin
          state_q    <= StResp;
          tx_valid_q <= 1'b1;
          if (is_wr_q) begin
            tx_data_q <= 8'h4B;
            cnt_q     <= 2'd0;
          end else begin
            tx_data_q <= rdata_i[31:24];
            resp_q    <= rdata_i;
            cnt_q     <= 2'd3;
          end
        end
        StResp: begin
          // cnt_q holds the number of bytes still to follow the one on offer.
          if (tx_ready_i) begin
            if (cnt_q == 2'd0) begin
              tx_valid_q <= 1'b0;
              state_q    <= StIdle;
            end else begin
              cnt_q     <= cnt_q - 2'd1;
              tx_data_q <= resp_q[23:16];
              resp_q    <= {resp_q[23:0], 8'h00};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (rx_valid_i && (state_q == StBus || state_q == StResp)) overrun_q <= 1'b1;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign rd_o       = rd_q;
  assign wr_o       = wr_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign busy_o     = (state_q != StIdle);
  assign overrun_o  = overrun_q;

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the inter-byte timeout in clk cycles while a command frame is incomplete.
REQ-002 Parameter CMD_WR, default 8'h57, SHALL be the write-command byte.
REQ-003 Parameter CMD_RD, default 8'h52, SHALL be the read-command byte.
REQ-004 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  received byte from the UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-008 tx_data  output  8  byte to send; SHALL be stable while tx_valid=1.
REQ-009 tx_valid  output  1  byte offered to the UART sender.
REQ-010 tx_ready  input  1  sender idle; a byte transfers on a cycle with tx_valid=1 and tx_ready=1.
REQ-011 rd  output  1  one-cycle bus read strobe.
REQ-012 wr  output  1  one-cycle bus write strobe.
REQ-013 addr  output  32  bus address.
REQ-014 wdata  output  32  bus write data.
REQ-015 rdata  input  32  bus read data, combinational; valid in the same cycle as rd.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 overrun  output  1  sticky flag: an rx byte was dropped during BUS or RESP.

Function
REQ-018 Frame format SHALL be: write = CMD_WR, 4 address bytes, 4 data bytes; read = CMD_RD, 4 address bytes. All multi-byte fields are MSB first.
REQ-019 States SHALL be IDLE, ADDR, DATA, BUS, RESP.
REQ-020 IDLE: rx_valid with CMD_WR or CMD_RD SHALL latch the command and go to ADDR with the byte count cleared.
REQ-021 IDLE: rx_valid with any other byte SHALL go to RESP with a single response byte 8'h3F.
REQ-022 ADDR: each rx_valid SHALL shift rx_data into the low byte of addr. After the 4th byte: write goes to DATA, read goes to BUS.
REQ-023 DATA: each rx_valid SHALL shift rx_data into wdata. After the 4th byte the block goes to BUS.
REQ-024 BUS SHALL last exactly one cycle and assert exactly one of wr or rd, with addr and wdata held. A read SHALL capture rdata into the response register in that cycle. The block then goes to RESP.
REQ-025 Latency: the strobe SHALL be in the cycle after the final frame byte's rx_valid; tx_valid SHALL rise in the cycle after the strobe.
REQ-026 RESP write: send one byte 8'h4B. RESP read: send the captured data as 4 bytes, MSB first.
REQ-027 Each handshake SHALL advance to the next byte. tx_valid SHALL stay high with tx_data unchanged until the handshake occurs, with no timeout.
REQ-028 After the last response byte's handshake, the block SHALL return to IDLE, with tx_valid=0 in the next cycle.
REQ-029 rx_valid during BUS or RESP SHALL drop the byte and set overrun. Overrun clears only on reset.
REQ-030 Timeout counter: cleared on every accepted rx_valid and on entry to ADDR; counts each cycle in ADDR or DATA.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES-1 with no rx_valid, the block SHALL return to IDLE with no bus access and no response.
REQ-032 If rx_valid arrives in the same cycle the counter reaches its limit, the byte SHALL win: it is accepted and the counter is cleared.
REQ-033 rd and wr SHALL never be high outside BUS and never both high.
REQ-034 addr and wdata SHALL hold their values until overwritten by the next frame.

Reset
REQ-035 reset=0 SHALL asynchronously force: state IDLE; rd=0, wr=0, tx_valid=0, busy=0, overrun=0; addr, wdata, tx_data and the response register to 0; byte count and timeout counter to 0.
REQ-036 Reset asserted mid-frame or mid-response SHALL discard all progress. The first byte after release is treated as a command byte.

Verification
REQ-037 Write: 57 40 00 00 0C 00 00 00 A5 with tx_ready=1 -> one cycle with wr=1, addr=32'h4000000C, wdata=32'h000000A5; then tx byte 4B; busy low afterwards.
REQ-038 Read: 52 40 00 00 10, rdata=32'h12345678 -> one cycle with rd=1, addr=32'h40000010; tx bytes 12 34 56 78 in order.
REQ-039 Backpressure: during the read response, hold tx_ready=0 for 10 cycles -> tx_valid stays 1 and tx_data stays 12 throughout; no byte is lost or repeated.
REQ-040 Bad command: byte 41 -> tx byte 3F; no rd or wr; back to IDLE.
REQ-041 Timeout: with TIMEOUT_CYCLES=16, send 57 40, then silence for 16 cycles -> IDLE with no strobe. A following complete read frame executes normally.
REQ-042 Overrun/reset: send a byte during RESP -> overrun=1 and the response is unaltered. Pulse reset=0 mid-frame -> all outputs return to reset values and overrun=0.
